// File: rtl/adc_spi_capture_if.sv
// Signals between the ADC capture block, the serial ADC and the sample FIFO.
// The master side is the capture block: it drives the ADC strobes and the FIFO write port.
interface adc_spi_capture_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  adc_cs_n;
    logic                  adc_sclk;
    logic                  adc_sdo;
    logic                  fifo_wr;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_full;

    modport master (
        output adc_cs_n,
        output adc_sclk,
        output fifo_wr,
        output fifo_data,
        input  adc_sdo,
        input  fifo_full
    );

    modport slave (
        input  adc_cs_n,
        input  adc_sclk,
        input  fifo_wr,
        input  fifo_data,
        output adc_sdo,
        output fifo_full
    );
endinterface

// File: rtl/adc_spi_capture.sv
// Paced serial ADC reader (CPOL=1): one frame per sample tick, each result pushed to the FIFO
// with a single-cycle strobe; full-FIFO drops and ticks missed during a frame are counted.
module adc_spi_capture #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned FRAME_BITS    = 16,
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    adc_spi_capture_if.master bus,
    output logic              busy,
    output logic [15:0]       drop_cnt
);
    localparam int unsigned CntW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BitW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [CntW-1:0] CntMax = CntW'(SAMPLE_PERIOD - 1);
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
    localparam logic [BitW-1:0] BitMax = BitW'(FRAME_BITS - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StStore = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DivW-1:0]       div_q, div_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic                  sclk_q, sclk_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [15:0]           drop_q, drop_d;

    logic                  tick;
    logic                  wr;
    logic [1:0]            drop_inc;
    logic [16:0]           drop_sum;

    assign tick = enable && (cnt_q == CntMax);
    // An abort (enable low) in the STORE cycle discards the frame like any other partial frame.
    assign wr   = (state_q == StStore) && enable && !bus.fifo_full;

    always_comb begin
        cnt_d    = cnt_q;
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sclk_d   = sclk_q;
        frame_d  = frame_q;
        data_d   = data_q;
        drop_inc = 2'd0;

        if (!enable || cnt_q == CntMax) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StShift;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            StShift: begin
                if (tick) begin
                    drop_inc = drop_inc + 2'd1;
                end
                if (div_q == DivMax) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        // Sample on the same edge that raises SCLK.
                        sclk_d  = 1'b1;
                        frame_d = {frame_q[FRAME_BITS-2:0], bus.adc_sdo};
                    end else if (bit_q == BitMax) begin
                        state_d = StStore;
                    end else begin
                        sclk_d = 1'b0;
                        bit_d  = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StStore: begin
                state_d = StIdle;
                if (tick) begin
                    drop_inc = drop_inc + 2'd1;
                end
                if (enable && bus.fifo_full) begin
                    drop_inc = drop_inc + 2'd1;
                end
                if (wr) begin
                    data_d = frame_q[DATA_WIDTH-1:0];
                end
            end
            default: begin
                state_d = StIdle;
                sclk_d  = 1'b1;
            end
        endcase

        if (!enable) begin
            state_d  = StIdle;
            sclk_d   = 1'b1;
            drop_inc = 2'd0;
        end

        drop_sum = {1'b0, drop_q} + {15'd0, drop_inc};
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b1;
            frame_q <= '0;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            frame_q <= frame_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    // Chip select and busy follow the state so reset releases them immediately.
    assign bus.adc_cs_n  = (state_q != StShift);
    assign bus.adc_sclk  = sclk_q;
    assign bus.fifo_wr   = wr;
    assign bus.fifo_data = wr ? frame_q[DATA_WIDTH-1:0] : data_q;
    assign busy          = (state_q == StShift);
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Bench for adc_spi_capture: directed frame table, reset/abort sequences, and a randomized run
// of two configurations against a tick-schedule reference model.
module tb_adc_spi_capture;
    localparam int NB   = 16;
    localparam int SP_A = 1000;
    localparam int D_A  = 4;
    localparam int SP_B = 50;
    localparam int D_B  = 2;
    localparam int LAT_A = 1 + 2 * NB * D_A;

    typedef struct {
        logic [15:0] word;
        logic        full;
        logic        exp_wr;
        logic [15:0] exp_data;
        logic [15:0] exp_drop;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b;
    logic        busy_a, busy_b;
    logic [15:0] drop_a, drop_b;
    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;

    adc_spi_capture_if #(.DATA_WIDTH(16)) bus_a ();
    adc_spi_capture_if #(.DATA_WIDTH(16)) bus_b ();

    adc_spi_capture #(
        .DATA_WIDTH(16), .FRAME_BITS(16), .CLK_DIV(D_A), .SAMPLE_PERIOD(SP_A)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .bus(bus_a), .busy(busy_a), .drop_cnt(drop_a)
    );

    // Deliberately over-committed: the frame outlasts the sample period.
    adc_spi_capture #(
        .DATA_WIDTH(16), .FRAME_BITS(16), .CLK_DIV(D_B), .SAMPLE_PERIOD(SP_B)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .bus(bus_b), .busy(busy_b), .drop_cnt(drop_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endfunction

    // ADC model: latches a word when CS falls, presents bit k after k SCLK rises.
    logic        prev_cs [2];
    logic        prev_sclk [2];
    int          adc_k [2];
    logic [15:0] cur_word [2];
    logic [15:0] next_word [2];
    logic        rand_word [2];
    logic        skip_cnt [2];

    function automatic logic adc_step(input int id, input logic cs_n, input logic sclk);
        if (prev_cs[id] && !cs_n) begin
            cur_word[id] = next_word[id];
            adc_k[id] = 0;
            if (rand_word[id]) next_word[id] = 16'($urandom);
        end else if (!cs_n && !prev_sclk[id] && sclk) begin
            adc_k[id]++;
        end
        if (!prev_cs[id] && cs_n) begin
            if (!skip_cnt[id]) check("sclk_rises_per_frame", 64'(adc_k[id]), 64'(NB));
            skip_cnt[id] = 1'b0;
        end
        prev_cs[id] = cs_n;
        prev_sclk[id] = sclk;
        return (!cs_n && adc_k[id] < NB) ? cur_word[id][NB-1-adc_k[id]] : 1'b0;
    endfunction

    always @(negedge clk) begin
        bus_a.adc_sdo <= adc_step(0, bus_a.adc_cs_n, bus_a.adc_sclk);
        bus_b.adc_sdo <= adc_step(1, bus_b.adc_cs_n, bus_b.adc_sclk);
    end

    // Reference model: tick every sp cycles after enable; a tick while idle opens a frame
    // that busies the ADC for lat-1 cycles and stores on cycle tick+lat; other ticks are missed.
    logic        m_on [2];
    int          m_rel [2];
    int          m_t [2];
    int          m_drop [2];
    logic [15:0] m_data [2];

    function automatic void model_step(input int id, input int sp, input int d,
                                       input logic full, input logic cs_n, input logic sclk,
                                       input logic busy, input logic wr,
                                       input logic [15:0] data, input logic [15:0] drop);
        int          c      = m_rel[id];
        int          lat    = 1 + 2 * NB * d;
        logic        have   = (m_t[id] >= 0);
        logic        busy_e = have && c > m_t[id] && c < m_t[id] + lat;
        logic        store  = have && c == m_t[id] + lat;
        logic        tick   = (c % sp) == sp - 1;
        logic        sclk_e = busy_e ? ((((c - m_t[id] - 1) / d) % 2) == 1) : 1'b1;
        logic        wr_e   = store && !full;
        logic [15:0] data_e = wr_e ? cur_word[id] : m_data[id];
        int          inc    = int'(store && full) + int'(tick && (busy_e || store));
        check(id == 0 ? "model_a" : "model_b", 64'({cs_n, sclk, busy, wr, data, drop}),
              64'({!busy_e, sclk_e, busy_e, wr_e, data_e, 16'(m_drop[id])}));
        m_data[id] = data_e;
        m_drop[id] = (m_drop[id] + inc > 65535) ? 65535 : m_drop[id] + inc;
        if (tick && !(busy_e || store)) m_t[id] = c;
        m_rel[id] = c + 1;
    endfunction

    always @(negedge clk) begin
        if (m_on[0]) model_step(0, SP_A, D_A, bus_a.fifo_full, bus_a.adc_cs_n, bus_a.adc_sclk,
                                busy_a, bus_a.fifo_wr, bus_a.fifo_data, drop_a);
        if (m_on[1]) model_step(1, SP_B, D_B, bus_b.fifo_full, bus_b.adc_cs_n, bus_b.adc_sclk,
                                busy_b, bus_b.fifo_wr, bus_b.fifo_data, drop_b);
    end

    task automatic wait_cs(input logic lvl, input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound && at < 0; i++) begin
            @(negedge clk);
            if (bus_a.adc_cs_n === lvl) at = cyc;
        end
    endtask

    task automatic wait_wr(input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound && at < 0; i++) begin
            @(negedge clk);
            if (bus_a.fifo_wr === 1'b1) at = cyc;
        end
    endtask

    function automatic logic [63:0] outs_a();
        return 64'({bus_a.adc_cs_n, bus_a.adc_sclk, busy_a, bus_a.fifo_wr, bus_a.fifo_data,
                    drop_a});
    endfunction

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [7];
        int   at;
        int   e0;
        int   r;

        tbl[0] = '{16'hA5C3, 1'b0, 1'b1, 16'hA5C3, 16'd0};
        tbl[1] = '{16'h0001, 1'b0, 1'b1, 16'h0001, 16'd0};
        tbl[2] = '{16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 16'd0};
        tbl[3] = '{16'h1234, 1'b1, 1'b0, 16'hFFFF, 16'd1};
        tbl[4] = '{16'h5A5A, 1'b0, 1'b1, 16'h5A5A, 16'd1};
        tbl[5] = '{16'h8000, 1'b1, 1'b0, 16'h5A5A, 16'd2};
        tbl[6] = '{16'h0F0F, 1'b0, 1'b1, 16'h0F0F, 16'd2};

        for (int i = 0; i < 2; i++) begin
            prev_cs[i] = 1'b1; prev_sclk[i] = 1'b1; adc_k[i] = 0;
            cur_word[i] = '0; next_word[i] = '0; rand_word[i] = 1'b0; skip_cnt[i] = 1'b0;
            m_on[i] = 1'b0; m_rel[i] = 0; m_t[i] = -1; m_drop[i] = 0; m_data[i] = '0;
        end
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
        bus_a.fifo_full = 1'b0; bus_b.fifo_full = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_a", outs_a(), 64'({1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0}));
        check("reset_b", 64'({bus_b.adc_cs_n, bus_b.adc_sclk, busy_b, bus_b.fifo_wr,
                              bus_b.fifo_data, drop_b}),
              64'({1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0}));

        // Directed frame table.
        @(posedge clk); #1;
        rst = 1'b0; en_a = 1'b1; e0 = cyc;
        for (int i = 0; i < 7; i++) begin
            next_word[0] = tbl[i].word;
            wait_cs(1'b0, SP_A + 50, at);
            check("cs_fall_cycle", 64'(at), 64'(e0 + SP_A * (i + 1)));
            @(posedge clk); #1;
            bus_a.fifo_full = tbl[i].full;
            wait_cs(1'b1, LAT_A + 10, at);
            check("store_cycle", 64'(at), 64'(e0 + SP_A * (i + 1) + LAT_A - 1));
            check("store_wr_data", 64'({bus_a.fifo_wr, bus_a.fifo_data}),
                  64'({tbl[i].exp_wr, tbl[i].exp_data}));
            @(negedge clk);
            check("after_store", 64'({bus_a.fifo_wr, bus_a.fifo_data, drop_a}),
                  64'({1'b0, tbl[i].exp_data, tbl[i].exp_drop}));
            @(posedge clk); #1;
            bus_a.fifo_full = 1'b0;
        end

        // Reset in the middle of a frame.
        next_word[0] = 16'hC0DE;
        wait_cs(1'b0, SP_A + 50, at);
        repeat (30) @(negedge clk);
        #2;
        skip_cnt[0] = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_mid_frame", outs_a(), 64'({1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0}));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; r = cyc;
        wait_wr(SP_A + LAT_A + 20, at);
        check("first_wr_after_rst", 64'(at), 64'(r + SP_A - 1 + LAT_A));
        check("data_after_rst", 64'(bus_a.fifo_data), 64'(16'hC0DE));

        // Reset during the STORE cycle itself.
        wait_cs(1'b0, SP_A + 50, at);
        wait_cs(1'b1, LAT_A + 10, at);
        check("store_before_rst", 64'(bus_a.fifo_wr), 64'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_store", outs_a(), 64'({1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0}));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; r = cyc;
        next_word[0] = 16'h7E81;
        wait_wr(SP_A + LAT_A + 20, at);
        check("wr_after_store_rst", 64'(at), 64'(r + SP_A - 1 + LAT_A));
        check("data_after_store_rst", 64'(bus_a.fifo_data), 64'(16'h7E81));

        // Enable dropped during SCLK bit 7 aborts the frame.
        wait_cs(1'b0, SP_A + 50, at);
        repeat (2 * 7 * D_A) @(posedge clk);
        #1;
        skip_cnt[0] = 1'b1;
        en_a = 1'b0;
        @(negedge clk);
        check("abort_same_cycle_cs", 64'(bus_a.adc_cs_n), 64'(1'b0));
        @(negedge clk);
        check("abort_next_cycle", 64'({bus_a.adc_cs_n, bus_a.adc_sclk, busy_a, bus_a.fifo_wr}),
              64'(4'b1100));
        wait_wr(300, at);
        check("no_wr_after_abort", 64'(at), 64'(-1));
        check("drop_after_abort", 64'(drop_a), 64'(16'd0));
        @(posedge clk); #1;
        en_a = 1'b1; e0 = cyc;
        next_word[0] = 16'h3C96;
        wait_wr(SP_A + LAT_A + 20, at);
        check("wr_after_reenable", 64'(at), 64'(e0 + SP_A - 1 + LAT_A));
        check("data_after_reenable", 64'(bus_a.fifo_data), 64'(16'h3C96));

        // Randomized run of both configurations against the reference model.
        @(posedge clk); #1;
        skip_cnt[0] = 1'b1;
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        skip_cnt[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_word[i] = 1'b1; next_word[i] = 16'($urandom);
            m_rel[i] = 0; m_t[i] = -1; m_drop[i] = 0; m_data[i] = '0; m_on[i] = 1'b1;
        end
        rst = 1'b0; en_a = 1'b1; en_b = 1'b1;
        for (int i = 0; i < 5600; i++) begin
            @(posedge clk); #1;
            bus_a.fifo_full = ($urandom_range(3) == 0);
            bus_b.fifo_full = ($urandom_range(3) == 0);
        end
        m_on[0] = 1'b0; m_on[1] = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
